// File: rtl/vga_pixel_fetch_if.sv
// Frame-buffer read port between the pixel fetcher (master) and the
// dual-bank frame-buffer RAM (slave).
interface vga_pixel_fetch_if #(
   parameter int ADDR_W = 17,
   parameter int PIX_W  = 12
);
   logic              fb_rd_en;
   logic              fb_rd_bank;
   logic [ADDR_W-1:0] fb_rd_addr;
   logic [PIX_W-1:0]  fb_rd_data;

   modport master (output fb_rd_en, fb_rd_bank, fb_rd_addr, input fb_rd_data);
   modport slave  (input fb_rd_en, fb_rd_bank, fb_rd_addr, output fb_rd_data);
endinterface

// File: rtl/vga_pixel_fetch.sv
// VGA pixel fetch: maps the 640x480 raster onto a 320x240 RGB444 frame
// buffer (2x upscale), reads it with a fixed latency, delays sync/valid to
// match, and owns the front/back bank swap with the capture writer.
// Output latency L = RD_LATENCY + 2 edges from input sample to pins.
module vga_pixel_fetch #(
   parameter int RD_LATENCY = 2,
   parameter int ADDR_W     = 17,
   parameter int PIX_W      = 12
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [9:0] row_in,
   input  logic [9:0] col_in,
   input  logic       valid_in,
   input  logic       hsync_in,
   input  logic       vsync_in,
   input  logic       swap_req,
   output logic       swap_ack,
   output logic       disp_bank,
   vga_pixel_fetch_if.master fb,
   output logic [3:0] vga_r,
   output logic [3:0] vga_g,
   output logic [3:0] vga_b,
   output logic       vga_hsync,
   output logic       vga_vsync
);
   localparam int L  = RD_LATENCY + 2;
   // stage A plus the RAM latency; the output register is the last stage
   localparam int DL = L - 1;

   typedef enum logic [1:0] {S_IDLE, S_ARMED, S_ACK} swap_st_t;

   logic [8:0]        w_r, w_c;
   logic [ADDR_W-1:0] w_addr;
   logic              w_boundary;

   logic              r_rd_en, r_rd_bank;
   logic [ADDR_W-1:0] r_rd_addr;
   logic [DL-1:0]     r_vld_dl, r_hs_dl, r_vs_dl;
   logic [PIX_W-1:0]  r_pix;
   logic              r_hs, r_vs;
   swap_st_t          r_st;
   logic              r_disp_bank, r_swap_ack;

   // row*320 + col on the half-resolution grid, as 256r + 64r + c
   assign w_r        = row_in[9:1];
   assign w_c        = col_in[9:1];
   assign w_addr     = (ADDR_W'(w_r) << 8) + (ADDR_W'(w_r) << 6) + ADDR_W'(w_c);
   assign w_boundary = (row_in == 10'd480) && (col_in == 10'd0);

   // stage A: issue the read; address holds through blanking
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rd_en   <= 1'b0;
         r_rd_bank <= 1'b0;
         r_rd_addr <= '0;
      end else begin
         r_rd_en   <= valid_in;
         r_rd_bank <= r_disp_bank;
         if (valid_in) r_rd_addr <= w_addr;
      end
   end

   // valid/sync delay line running alongside the RAM read
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_vld_dl <= '0;
         r_hs_dl  <= '0;
         r_vs_dl  <= '1;
      end else begin
         r_vld_dl <= {r_vld_dl[DL-2:0], valid_in};
         r_hs_dl  <= {r_hs_dl[DL-2:0],  hsync_in};
         r_vs_dl  <= {r_vs_dl[DL-2:0],  vsync_in};
      end
   end

   // output register: blank outside the visible area
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pix <= '0;
         r_hs  <= 1'b0;
         r_vs  <= 1'b1;
      end else begin
         r_pix <= r_vld_dl[DL-1] ? fb.fb_rd_data : '0;
         r_hs  <= r_hs_dl[DL-1];
         r_vs  <= r_vs_dl[DL-1];
      end
   end

   // bank swap: arm on request, flip at row 480 col 0, wait for request release
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_st        <= S_IDLE;
         r_disp_bank <= 1'b0;
         r_swap_ack  <= 1'b0;
      end else begin
         r_swap_ack <= 1'b0;
         case (r_st)
            S_IDLE:  if (swap_req) r_st <= S_ARMED;
            S_ARMED: begin
               if (!swap_req) begin
                  r_st <= S_IDLE;
               end else if (w_boundary) begin
                  r_disp_bank <= ~r_disp_bank;
                  r_swap_ack  <= 1'b1;
                  r_st        <= S_ACK;
               end
            end
            S_ACK:   if (!swap_req) r_st <= S_IDLE;
            default: r_st <= S_IDLE;
         endcase
      end
   end

   assign fb.fb_rd_en   = r_rd_en;
   assign fb.fb_rd_bank = r_rd_bank;
   assign fb.fb_rd_addr = r_rd_addr;
   assign swap_ack      = r_swap_ack;
   assign disp_bank     = r_disp_bank;
   assign vga_r         = r_pix[PIX_W-1 -: 4];
   assign vga_g         = r_pix[PIX_W-5 -: 4];
   assign vga_b         = r_pix[3:0];
   assign vga_hsync     = r_hs;
   assign vga_vsync     = r_vs;
endmodule

// File: tb/tb_vga_pixel_fetch.sv
// Bench for vga_pixel_fetch: three instances (RD_LATENCY 2, 1, 4) share one
// raster/swap stimulus; a frame-level reference model predicts pins.
module tb_vga_pixel_fetch;
   localparam int NI = 3;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [9:0] row, col;
   logic       valid, hs, vs, req;

   wire [NI-1:0][11:0] o_rgb;
   wire [NI-1:0][16:0] o_addr;
   wire [NI-1:0]       o_hs, o_vs, o_ack, o_bank, o_en;

   int unsigned seed;
   int total = 0, bad = 0;

   always #20 clk = ~clk;

   function automatic int lat_of(input int g);
      return ((g == 0) ? 2 : (g == 1) ? 1 : 4) + 2;
   endfunction

   // frame-buffer contents: fixed pattern with one known pixel
   function automatic logic [11:0] mem(input logic bank, input logic [16:0] a);
      logic [31:0] h;
      if (!bank && a == 17'd322) return 12'hA5C;
      h = (32'(a) * 32'd2654435761) ^ seed ^ (bank ? 32'h0005A500 : 32'h0);
      return h[19:8];
   endfunction

   function automatic logic [16:0] map(input int r, input int c);
      return 17'((r / 2) * 320 + c / 2);
   endfunction

   for (genvar g = 0; g < NI; g++) begin : g_dut
      localparam int RD = (g == 0) ? 2 : (g == 1) ? 1 : 4;
      vga_pixel_fetch_if #(.ADDR_W(17), .PIX_W(12)) fif ();
      logic [11:0] pipe [RD];
      always @(posedge clk) begin
         pipe[0] <= fif.fb_rd_en ? mem(fif.fb_rd_bank, fif.fb_rd_addr) : 12'hEEE;
         for (int k = 1; k < RD; k++) pipe[k] <= pipe[k-1];
      end
      assign fif.fb_rd_data = pipe[RD-1];
      assign o_en[g]   = fif.fb_rd_en;
      assign o_addr[g] = fif.fb_rd_addr;
      vga_pixel_fetch #(.RD_LATENCY(RD), .ADDR_W(17), .PIX_W(12)) dut (
         .clk(clk), .rst_n(rst_n), .row_in(row), .col_in(col), .valid_in(valid),
         .hsync_in(hs), .vsync_in(vs), .swap_req(req), .swap_ack(o_ack[g]),
         .disp_bank(o_bank[g]), .fb(fif),
         .vga_r(o_rgb[g][11:8]), .vga_g(o_rgb[g][7:4]), .vga_b(o_rgb[g][3:0]),
         .vga_hsync(o_hs[g]), .vga_vsync(o_vs[g]));
   end

   // ---------------- reference model ----------------
   typedef struct packed {logic v; logic hs; logic vs; logic bank; logic [16:0] addr;} hent_t;
   hent_t hist [16];
   int    ecnt = 0, last_rst = 0;
   logic  m_bank, m_run, m_used, m_ack;
   logic [16:0] m_addr;

   // input history per edge, with the bank that was displayed when sampled
   always @(posedge clk) begin
      ecnt <= ecnt + 1;
      hist[(ecnt + 1) % 16] <= '{valid, hs, vs, m_bank, map(row, col)};
      if (!rst_n) last_rst <= ecnt + 1;
   end

   // swap rule: one swap per continuous high run of swap_req, at a boundary
   // that is not the first high sample of the run
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_bank <= 0; m_run <= 0; m_used <= 0; m_ack <= 0; m_addr <= '0;
      end else begin
         m_ack <= 0;
         if (valid) m_addr <= map(row, col);
         if (!req) begin
            m_run <= 0; m_used <= 0;
         end else if (m_run && !m_used && row == 10'd480 && col == 10'd0) begin
            m_bank <= ~m_bank; m_used <= 1; m_ack <= 1;
         end else begin
            m_run <= 1;
         end
      end
   end

   function automatic void expv(input int lat, output logic [11:0] e_rgb,
                                output logic e_hs, output logic e_vs);
      int n;
      hent_t h;
      n = ecnt - lat + 1;
      if (n <= last_rst) begin
         e_rgb = '0; e_hs = 1'b0; e_vs = 1'b1;
      end else begin
         h = hist[n % 16];
         e_rgb = h.v ? mem(h.bank, h.addr) : 12'h0;
         e_hs = h.hs; e_vs = h.vs;
      end
   endfunction

   // ---------------- stimulus ----------------
   int fr [8];
   int t_px, t_bank, t_addr, t_acks, t_nz, ack_r, ack_c, f_cyc, f_g;
   logic [13:0] f_got, f_exp;
   logic exp_bank = 1'b0;

   task automatic drive(input int r, input int c);
      row   = 10'(r);
      col   = 10'(c);
      valid = (r < 480) && (c < 640);
      hs    = (c >= 656) && (c < 752);
      vs    = !((r >= 490) && (r < 492));
   endtask

   function automatic logic req_for(input int mode, input int r);
      case (mode)
         1: return r >= 100;
         2: return 1'b1;
         4: return (r >= 100) && (r < 200);
         5: return r >= 480;
         default: return 1'b0;
      endcase
   endfunction

   task automatic clear_tallies();
      t_px = 0; t_bank = 0; t_addr = 0; t_acks = 0; t_nz = 0;
      ack_r = -1; ack_c = -1; f_cyc = 0; f_g = 0; f_got = '0; f_exp = '0;
   endtask

   // drive columns c0..c1-1 of one line and tally disagreements with the model
   task automatic run_line(input int r, input int c0, input int c1, input int mode);
      logic [11:0] er;
      logic eh, ev;
      for (int c = c0; c < c1; c++) begin
         drive(r, c);
         req = req_for(mode, r);
         @(negedge clk);
         for (int g = 0; g < NI; g++) begin
            expv(lat_of(g), er, eh, ev);
            if ({o_rgb[g], o_hs[g], o_vs[g]} !== {er, eh, ev}) begin
               if (t_px == 0) begin
                  f_cyc = ecnt; f_g = g; f_got = {o_rgb[g], o_hs[g], o_vs[g]}; f_exp = {er, eh, ev};
               end
               t_px++;
            end
            if ({o_bank[g], o_ack[g]} !== {m_bank, m_ack}) t_bank++;
            if (o_addr[g] !== m_addr) t_addr++;
         end
         if (o_ack[0] === 1'b1) begin t_acks++; ack_r = r; ack_c = c; end
         if (o_rgb[0] != 12'h0) t_nz++;
      end
   endtask

   task automatic run_frame(input int mode);
      for (int i = 0; i < 8; i++) run_line(fr[i], 0, 800, mode);
   endtask

   task automatic test_reset();
      rst_n = 0; req = 0; drive(0, 700);
      repeat (5) @(negedge clk);
      for (int g = 0; g < NI; g++) begin
         total++;
         if ({o_rgb[g], o_hs[g], o_vs[g], o_bank[g], o_ack[g], o_en[g], o_addr[g]} !==
             {12'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 17'h0}) begin
            bad++;
            $display("FAIL reset_state[%0d] got rgb=%h hs=%b vs=%b bank=%b ack=%b en=%b addr=%0d",
                     g, o_rgb[g], o_hs[g], o_vs[g], o_bank[g], o_ack[g], o_en[g], o_addr[g]);
         end
      end
      rst_n = 1;
      repeat (8) @(negedge clk);
   endtask

   task automatic test_addr_map();
      int rr [7] = '{0, 0, 0, 0, 478, 479, 479};
      int cc [7] = '{0, 1, 2, 3, 0, 0, 639};
      int ea [7] = '{0, 0, 1, 1, 76480, 76480, 76799};
      int r, c;
      drive(3, 5);
      @(negedge clk);
      total++;
      if ({o_en[0], o_addr[0]} !== {1'b1, 17'd322}) begin
         bad++; $display("FAIL addr_322 got en=%b addr=%0d exp en=1 addr=322", o_en[0], o_addr[0]);
      end
      drive(3, 700);
      for (int k = 2; k <= 6; k++) begin
         @(negedge clk);
         if (k == 2) begin
            total++;
            if ({o_en[0], o_addr[0]} !== {1'b0, 17'd322}) begin
               bad++; $display("FAIL addr_hold got en=%b addr=%0d exp en=0 addr=322", o_en[0], o_addr[0]);
            end
         end
         for (int g = 0; g < NI; g++) begin
            if (k == lat_of(g)) begin
               total++;
               if (o_rgb[g] !== 12'hA5C) begin
                  bad++; $display("FAIL pix_322[%0d] got=%h exp=a5c", g, o_rgb[g]);
               end
            end
         end
      end
      for (int i = 0; i < 13; i++) begin
         if (i < 7) begin r = rr[i]; c = cc[i]; end
         else begin r = $urandom_range(0, 479); c = $urandom_range(0, 639); end
         drive(r, c);
         @(negedge clk);
         total++;
         if (o_addr[0] !== ((i < 7) ? 17'(ea[i]) : 17'((r / 2) * 320 + c / 2))) begin
            bad++; $display("FAIL addr_map r=%0d c=%0d got=%0d exp=%0d", r, c, o_addr[0],
                            (i < 7) ? ea[i] : (r / 2) * 320 + c / 2);
         end
      end
   endtask

   task automatic test_frame();
      fr = '{0, 100, 200, 479, 480, 481, 490, 524};
      fr[1] = $urandom_range(1, 239);
      fr[2] = $urandom_range(240, 478);
      clear_tallies();
      run_frame(0);
      total++;
      if (t_px != 0) begin
         bad++; $display("FAIL frame_pixels count=%0d first cyc=%0d inst=%0d got=%h exp=%h",
                         t_px, f_cyc, f_g, f_got, f_exp);
      end
      total++;
      if (t_addr != 0 || t_bank != 0 || t_acks != 0) begin
         bad++; $display("FAIL frame_ctrl addr=%0d bank=%0d acks=%0d exp all 0", t_addr, t_bank, t_acks);
      end
      total++;
      if (t_nz == 0) begin
         bad++; $display("FAIL frame_nonblank got=0 nonzero pixels exp>0");
      end
   endtask

   task automatic test_swap();
      int modes [6] = '{1, 2, 1, 4, 5, 2};
      int acks  [6] = '{1, 0, 1, 0, 0, 1};
      fr = '{0, 100, 200, 479, 480, 481, 490, 524};
      for (int s = 0; s < 6; s++) begin
         clear_tallies();
         run_frame(modes[s]);
         if (acks[s] == 1) exp_bank = ~exp_bank;
         total++;
         if (t_acks != acks[s]) begin
            bad++; $display("FAIL swap_acks scen=%0d got=%0d exp=%0d", s, t_acks, acks[s]);
         end
         if (acks[s] == 1) begin
            total++;
            if (ack_r != 480 || ack_c != 0) begin
               bad++; $display("FAIL swap_ack_pos scen=%0d got r=%0d c=%0d exp r=480 c=0", s, ack_r, ack_c);
            end
         end
         total++;
         if (o_bank !== {NI{exp_bank}}) begin
            bad++; $display("FAIL swap_bank scen=%0d got=%b exp=%b", s, o_bank, exp_bank);
         end
         total++;
         if (t_px != 0 || t_bank != 0 || t_addr != 0) begin
            bad++; $display("FAIL swap_track scen=%0d px=%0d bank=%0d addr=%0d exp 0", s, t_px, t_bank, t_addr);
         end
      end
   endtask

   task automatic test_reset_midline();
      int r, k;
      r = $urandom_range(0, 470);
      k = $urandom_range(100, 600);
      clear_tallies();
      run_line(r, 0, k, 2);
      total++;
      if (o_bank[0] !== exp_bank) begin
         bad++; $display("FAIL pre_reset_bank got=%b exp=%b", o_bank[0], exp_bank);
      end
      drive(r, k);
      #2 rst_n = 0;
      #1;
      for (int g = 0; g < NI; g++) begin
         total++;
         if ({o_rgb[g], o_hs[g], o_vs[g], o_bank[g], o_ack[g], o_en[g]} !==
             {12'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL async_reset[%0d] got rgb=%h hs=%b vs=%b bank=%b ack=%b en=%b",
                     g, o_rgb[g], o_hs[g], o_vs[g], o_bank[g], o_ack[g], o_en[g]);
         end
      end
      @(negedge clk); drive(r, k + 1);
      @(negedge clk); drive(r, k + 2);
      @(negedge clk); rst_n = 1;
      exp_bank = 1'b0;
      drive(r, k + 3);
      @(negedge clk);
      total++;
      if ({o_rgb, o_hs, o_vs} !== {{NI{12'h0}}, {NI{1'b0}}, {NI{1'b1}}}) begin
         bad++; $display("FAIL post_reset_blank got rgb=%h hs=%b vs=%b", o_rgb, o_hs, o_vs);
      end
      clear_tallies();
      run_line(r, k + 4, 800, 2);
      run_line(r + 1, 0, 800, 2);
      total++;
      if (t_px != 0 || t_bank != 0 || t_addr != 0 || t_acks != 0) begin
         bad++; $display("FAIL post_reset_track px=%0d bank=%0d addr=%0d acks=%0d first cyc=%0d inst=%0d got=%h exp=%h",
                         t_px, t_bank, t_addr, t_acks, f_cyc, f_g, f_got, f_exp);
      end
   endtask

   initial begin
      seed = $urandom;
      rst_n = 0; req = 0; drive(0, 700);
      test_reset();
      test_addr_map();
      test_frame();
      test_swap();
      test_reset_midline();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #8000000;
      $display("FAIL timeout reached at %0t exp finish earlier", $time);
      $fatal(1);
   end
endmodule
